// File: rtl/game_state_ctrl.sv
// Game-phase sequencer: one-hot phase flags plus lives, level and countdown bookkeeping.
// Events are captured into pending bits and acted on only at frame boundaries.
module game_state_ctrl #(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned LEVELS          = 4,
  parameter int unsigned CONTINUE_FRAMES = 180,
  parameter int unsigned FINAL_FRAMES    = 300,
  localparam int unsigned MaxFrames = (CONTINUE_FRAMES > FINAL_FRAMES) ? CONTINUE_FRAMES
                                                                       : FINAL_FRAMES,
  localparam int unsigned LivesW = $clog2(LIVES_INIT + 1),
  localparam int unsigned LevelW = $clog2(LEVELS + 1),
  localparam int unsigned CountW = $clog2(MaxFrames + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_tick_i,
  input  logic              start_btn_i,
  input  logic              player_hit_i,
  input  logic              level_clear_i,
  output logic              is_menu_o,
  output logic              is_playing_o,
  output logic              is_continue_o,
  output logic              is_final_o,
  output logic [LivesW-1:0] lives_o,
  output logic [LevelW-1:0] level_o,
  output logic [CountW-1:0] countdown_o,
  output logic              game_won_o
);

  // One-hot encoding so each phase flag is a state register bit.
  typedef enum logic [3:0] {
    StMenu     = 4'b0001,
    StPlaying  = 4'b0010,
    StContinue = 4'b0100,
    StFinal    = 4'b1000
  } phase_e;

  localparam logic [LivesW-1:0] LivesInit  = LivesW'(LIVES_INIT);
  localparam logic [LivesW-1:0] LivesOne   = LivesW'(1);
  localparam logic [LevelW-1:0] LevelLast  = LevelW'(LEVELS - 1);
  localparam logic [CountW-1:0] CountCont  = CountW'(CONTINUE_FRAMES);
  localparam logic [CountW-1:0] CountFinal = CountW'(FINAL_FRAMES);
  localparam logic [CountW-1:0] CountOne   = CountW'(1);

  phase_e              phase_q;
  logic [LivesW-1:0]   lives_q;
  logic [LevelW-1:0]   level_q;
  logic [CountW-1:0]   count_q;
  logic                won_q;
  logic                start_prev_q;
  logic                start_pend_q;
  logic                hit_pend_q;
  logic                clr_pend_q;

  logic start_ev, hit_ev, clr_ev;
  logic start_now, hit_now, clr_now;

  // Qualified events: only those meaningful in the current phase are seen at all.
  assign start_ev = start_btn_i & ~start_prev_q & (phase_q != StPlaying);
  assign hit_ev   = player_hit_i & (phase_q == StPlaying);
  assign clr_ev   = level_clear_i & (phase_q == StPlaying);

  // An event arriving together with the tick counts for that tick.
  assign start_now = start_pend_q | start_ev;
  assign hit_now   = hit_pend_q | hit_ev;
  assign clr_now   = clr_pend_q | clr_ev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q      <= StMenu;
      lives_q      <= '0;
      level_q      <= '0;
      count_q      <= '0;
      won_q        <= 1'b0;
      start_prev_q <= 1'b1;
      start_pend_q <= 1'b0;
      hit_pend_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      start_prev_q <= start_btn_i;
      if (frame_tick_i) begin
        // Every tick consumes the pending bits, which also clears them on any phase entry.
        start_pend_q <= 1'b0;
        hit_pend_q   <= 1'b0;
        clr_pend_q   <= 1'b0;
        case (phase_q)
          StMenu: begin
            if (start_now) begin
              phase_q <= StPlaying;
              lives_q <= LivesInit;
              level_q <= '0;
              won_q   <= 1'b0;
            end
          end
          StPlaying: begin
            if (hit_now) begin
              if (lives_q <= LivesOne) begin
                phase_q <= StFinal;
                lives_q <= '0;
                won_q   <= 1'b0;
                count_q <= CountFinal;
              end else begin
                phase_q <= StContinue;
                lives_q <= lives_q - LivesOne;
                count_q <= CountCont;
              end
            end else if (clr_now) begin
              if (level_q >= LevelLast) begin
                phase_q <= StFinal;
                won_q   <= 1'b1;
                count_q <= CountFinal;
              end else begin
                phase_q <= StContinue;
                level_q <= level_q + LevelW'(1);
                count_q <= CountCont;
              end
            end
          end
          StContinue: begin
            if (start_now || count_q <= CountOne) begin
              phase_q <= StPlaying;
              count_q <= '0;
            end else begin
              count_q <= count_q - CountOne;
            end
          end
          StFinal: begin
            if (start_now || count_q <= CountOne) begin
              phase_q <= StMenu;
              count_q <= '0;
            end else begin
              count_q <= count_q - CountOne;
            end
          end
          default: phase_q <= StMenu;
        endcase
      end else begin
        if (start_ev) start_pend_q <= 1'b1;
        if (hit_ev)   hit_pend_q   <= 1'b1;
        if (clr_ev)   clr_pend_q   <= 1'b1;
      end
    end
  end

  assign is_menu_o     = phase_q[0];
  assign is_playing_o  = phase_q[1];
  assign is_continue_o = phase_q[2];
  assign is_final_o    = phase_q[3];
  assign lives_o       = lives_q;
  assign level_o       = level_q;
  assign countdown_o   = count_q;
  assign game_won_o    = won_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters (3 lives, 4 levels, 180/300 frames).
module tb_game_state_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       frame_tick_i;
  logic       start_btn_i;
  logic       player_hit_i;
  logic       level_clear_i;
  logic       is_menu_o, is_playing_o, is_continue_o, is_final_o;
  logic [1:0] lives_o;
  logic [2:0] level_o;
  logic [8:0] countdown_o;
  logic       game_won_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  game_state_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .frame_tick_i  (frame_tick_i),
    .start_btn_i   (start_btn_i),
    .player_hit_i  (player_hit_i),
    .level_clear_i (level_clear_i),
    .is_menu_o     (is_menu_o),
    .is_playing_o  (is_playing_o),
    .is_continue_o (is_continue_o),
    .is_final_o    (is_final_o),
    .lives_o       (lives_o),
    .level_o       (level_o),
    .countdown_o   (countdown_o),
    .game_won_o    (game_won_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Phase flags packed as {final, continue, playing, menu}.
  task automatic check_phase(input string tag, input logic [3:0] exp);
    check(tag, {is_final_o, is_continue_o, is_playing_o, is_menu_o}, exp);
  endtask

  localparam logic [3:0] PMenu = 4'b0001, PPlay = 4'b0010, PCont = 4'b0100, PFinal = 4'b1000;

  // All drives and samples happen 1 time unit after the rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i); #1 frame_tick_i = 1'b1;
    @(posedge clk_i); #1 frame_tick_i = 1'b0;
  endtask

  task automatic press();
    @(posedge clk_i); #1 start_btn_i = 1'b0;
    @(posedge clk_i); #1 start_btn_i = 1'b1;
    cycles(2);
  endtask

  task automatic hit();
    @(posedge clk_i); #1 player_hit_i = 1'b1;
    @(posedge clk_i); #1 player_hit_i = 1'b0;
  endtask

  task automatic clear();
    @(posedge clk_i); #1 level_clear_i = 1'b1;
    @(posedge clk_i); #1 level_clear_i = 1'b0;
  endtask

  always @(negedge clk_i)
    check("onehot", $onehot({is_final_o, is_continue_o, is_playing_o, is_menu_o}), 1);

  initial begin
    rst_i = 1'b1; frame_tick_i = 1'b0; start_btn_i = 1'b1;
    player_hit_i = 1'b0; level_clear_i = 1'b0;
    #1;
    check_phase("rst_phase", PMenu);
    check("rst_lives", lives_o, 0);
    check("rst_count", countdown_o, 0);
    check("rst_won", game_won_o, 0);
    cycles(3);
    @(posedge clk_i); #1 rst_i = 1'b0;
    // Held button through reset release is not an edge.
    tick(); tick();
    check_phase("held_start_menu", PMenu);
    // Hit in MENU must not latch and leak into PLAYING.
    hit();
    press();
    check_phase("pre_tick_menu", PMenu);
    tick();
    check_phase("start_play", PPlay);
    check("start_lives", lives_o, 3);
    check("start_level", level_o, 0);
    tick();
    check_phase("menu_hit_ignored", PPlay);
    check("menu_hit_lives", lives_o, 3);

    // Hit mid-frame takes effect only on tick.
    hit();
    cycles(4);
    check_phase("hit_no_tick", PPlay);
    check("hit_no_tick_lives", lives_o, 3);
    tick();
    check_phase("hit_cont", PCont);
    check("hit_lives", lives_o, 2);
    check("hit_count", countdown_o, 180);
    repeat (179) tick();
    check_phase("cont_last", PCont);
    check("cont_last_count", countdown_o, 1);
    tick();
    check_phase("cont_resume", PPlay);
    check("cont_resume_count", countdown_o, 0);

    // Hit and clear in the same frame: hit wins.
    hit(); clear();
    tick();
    check_phase("both_cont", PCont);
    check("both_lives", lives_o, 1);
    check("both_level", level_o, 0);
    press(); tick();
    check_phase("press_resume", PPlay);

    // Clear all four levels.
    for (int i = 0; i < 3; i++) begin
      clear(); tick();
      check_phase("clr_cont", PCont);
      check("clr_level", level_o, i + 1);
      check("clr_count", countdown_o, 180);
      press(); tick();
    end
    check_phase("lvl3_play", PPlay);
    clear(); tick();
    check_phase("win_final", PFinal);
    check("win_won", game_won_o, 1);
    check("win_level", level_o, 3);
    check("win_count", countdown_o, 300);
    tick();
    check("final_dec", countdown_o, 299);
    press(); tick();
    check_phase("win_menu", PMenu);
    check("win_hold_level", level_o, 3);
    check("win_hold_won", game_won_o, 1);

    // Lose all lives.
    press(); tick();
    check("new_lives", lives_o, 3);
    check("new_level", level_o, 0);
    check("new_won", game_won_o, 0);
    for (int i = 0; i < 2; i++) begin
      hit(); tick(); press(); tick();
    end
    check_phase("last_life_play", PPlay);
    check("last_life", lives_o, 1);
    hit(); tick();
    check_phase("lose_final", PFinal);
    check("lose_won", game_won_o, 0);
    check("lose_lives", lives_o, 0);
    check("lose_count", countdown_o, 300);
    press(); tick();
    check_phase("lose_menu", PMenu);

    // Async reset in CONTINUE with countdown 100.
    press(); tick();
    hit(); tick();
    repeat (80) tick();
    check("cont_100", countdown_o, 100);
    @(negedge clk_i); #2 rst_i = 1'b1;
    #1;
    check_phase("async_rst_phase", PMenu);
    check("async_rst_lives", lives_o, 0);
    check("async_rst_level", level_o, 0);
    check("async_rst_count", countdown_o, 0);
    cycles(2);
    rst_i = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
